// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stage: occupancy states,
// control-bundle bit map and a helper that derives state from the valid bits.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    localparam int CTRL_MEM_WEN = 0;
    localparam int CTRL_WB_SEL  = 1;
    localparam int CTRL_REG_WB  = 2;
    localparam int CTRL_AUIPC   = 3;

    localparam int                    CTRL_W_DEFAULT = 4;
    localparam logic [CTRL_W_DEFAULT-1:0] CTRL_ZERO  = '0;

    // The skid slot is only ever filled behind a valid main slot.
    function automatic state_e slotState(input logic mainValid, input logic skidValid);
        if (skidValid) begin
            return ST_FULL;
        end else if (mainValid) begin
            return ST_ONE;
        end else begin
            return ST_EMPTY;
        end
    endfunction

endpackage

// File: rtl/pipe_slot_reg.sv
// One holding slot: a valid bit plus payload register. Clear wins over load;
// clear drops only the valid bit, the payload keeps its last value.
module pipe_slot_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic         clear_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic inter-stage register: main slot plus one skid slot so in_ready can be
// registered, with flush, bubble gating of rd/ctrl and a saturating stall counter.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W               = 32,
    parameter int NUM_DATA             = 2,
    parameter int RD_W                 = 5,
    parameter int CTRL_W               = 4,
    parameter int CNT_W                = 16,
    parameter bit CLEAR_DATA_ON_BUBBLE = 1'b0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NUM_DATA*DATA_W-1:0] in_data,
    input  logic [RD_W-1:0]            in_rd,
    input  logic [CTRL_W-1:0]          in_ctrl,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NUM_DATA*DATA_W-1:0] out_data,
    output logic [RD_W-1:0]            out_rd,
    output logic [CTRL_W-1:0]          out_ctrl,
    output logic [CNT_W-1:0]           stall_cnt,
    input  logic                       stall_cnt_clr
);

    localparam int DW = NUM_DATA * DATA_W;
    localparam int PW = CTRL_W + RD_W + DW;

    logic          mainValid, skidValid;
    logic [PW-1:0] mainPayload, skidPayload, inPayload, mainSrc;
    logic          mainLoad, mainClear, skidLoad, skidClear;
    logic          inFire, outFire;
    state_e        state;
    logic [CNT_W-1:0] stallCnt_q, stallCnt_d;

    assign inPayload = {in_ctrl, in_rd, in_data};
    assign state     = slotState(mainValid, skidValid);
    assign in_ready  = ~skidValid;
    assign inFire    = in_valid & in_ready;
    assign outFire   = mainValid & out_ready;

    // Flush overrides every load so an input arriving with it is discarded.
    always_comb begin
        mainLoad  = 1'b0;
        mainClear = 1'b0;
        skidLoad  = 1'b0;
        skidClear = 1'b0;
        mainSrc   = inPayload;
        case (state)
            ST_EMPTY: mainLoad = inFire;
            ST_ONE: begin
                if (inFire && outFire) begin
                    mainLoad = 1'b1;
                end else if (inFire) begin
                    skidLoad = 1'b1;
                end else if (outFire) begin
                    mainClear = 1'b1;
                end
            end
            ST_FULL: begin
                if (outFire) begin
                    mainLoad  = 1'b1;
                    mainSrc   = skidPayload;
                    skidClear = 1'b1;
                end
            end
            default: ;
        endcase
        if (flush) begin
            mainLoad  = 1'b0;
            skidLoad  = 1'b0;
            mainClear = 1'b1;
            skidClear = 1'b1;
        end
    end

    pipe_slot_reg #(.W(PW)) u_main (
        .clk     (clk),
        .reset   (reset),
        .load_i  (mainLoad),
        .clear_i (mainClear),
        .data_i  (mainSrc),
        .valid_o (mainValid),
        .data_o  (mainPayload)
    );

    pipe_slot_reg #(.W(PW)) u_skid (
        .clk     (clk),
        .reset   (reset),
        .load_i  (skidLoad),
        .clear_i (skidClear),
        .data_i  (inPayload),
        .valid_o (skidValid),
        .data_o  (skidPayload)
    );

    always_comb begin
        stallCnt_d = stallCnt_q;
        if (stall_cnt_clr) begin
            stallCnt_d = '0;
        end else if (mainValid && !out_ready && !(&stallCnt_q)) begin
            stallCnt_d = stallCnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stallCnt_q <= '0;
        end else begin
            stallCnt_q <= stallCnt_d;
        end
    end

    assign stall_cnt = stallCnt_q;
    assign out_valid = mainValid;
    assign out_ctrl  = mainPayload[PW-1 -: CTRL_W] & {CTRL_W{mainValid}};
    assign out_rd    = mainPayload[DW +: RD_W] & {RD_W{mainValid}};

    generate
        if (CLEAR_DATA_ON_BUBBLE) begin : g_clearData
            assign out_data = mainPayload[DW-1:0] & {DW{mainValid}};
        end else begin : g_holdData
            assign out_data = mainPayload[DW-1:0];
        end
    endgenerate

    assert property (@(posedge clk) disable iff (reset) !(skidValid && !mainValid));

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised elastic pipeline register for the 5-stage core; next generation of the fixed inter-stage latches.
- Carries N data words, a destination-register index and a control bundle from one stage to the next.
- Adds valid/ready handshake with a 2-entry skid buffer, synchronous flush, bubble gating of control, and a saturating stall-cycle counter.
- Drop-in for EX/MEM, ID/EX and MEM/WB, so a stall or flush from the hazard unit no longer needs ad-hoc logic.

Parameters:
- DATA_W, 32, width of one data word
- NUM_DATA, 2, number of data words carried (e.g. ALU result, store data)
- RD_W, 5, destination register index width
- CTRL_W, 4, control bundle width (bit map in package)
- CNT_W, 16, stall counter width
- CLEAR_DATA_ON_BUBBLE, 0, when 1 data outputs read 0 while out_valid=0; when 0 they hold last value

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- flush  in  1  synchronous kill of all held entries
- in_valid  in  1  upstream entry present
- in_ready  out  1  stage can accept; equals NOT skid_valid
- in_data  in  NUM_DATA*DATA_W  word k at bits [k*DATA_W +: DATA_W]
- in_rd  in  RD_W  destination register index
- in_ctrl  in  CTRL_W  control bundle
- out_valid  out  1  main slot valid
- out_ready  in  1  downstream accepts
- out_data  out  NUM_DATA*DATA_W  main slot data
- out_rd  out  RD_W  main slot rd; 0 when out_valid=0
- out_ctrl  out  CTRL_W  main slot ctrl; all 0 when out_valid=0
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating
- stall_cnt_clr  in  1  synchronous clear of stall_cnt

Behaviour:
- Handshakes:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- Reset values:
  - Both valid bits 0, all payload registers 0, stall_cnt 0.
  - Hence in_ready=1 and out_valid=0.
  - out_data, out_rd and out_ctrl are 0.
- Latency and throughput:
  - Latency 1 cycle: an entry accepted at edge N is on out_* after edge N.
  - Throughput 1 entry/cycle while out_ready=1.
- States, derived from the two valid bits:
  - EMPTY: main invalid, skid invalid.
  - ONE: main valid, skid invalid.
  - FULL: both valid.
- Transitions:
  - EMPTY: in_fire -> ONE, main <= in.
  - ONE: in_fire & out_fire -> ONE, main <= in.
  - ONE: in_fire & !out_fire -> FULL, skid <= in.
  - ONE: out_fire only -> EMPTY.
  - FULL: in_ready=0. out_fire -> ONE, main <= skid, skid cleared.
  - Skid valid with main invalid is illegal; assert never.
- Hold rule: while out_valid=1 and out_ready=0, out_* must not change.
- Flush:
  - Next state is EMPTY from any state.
  - An input presented in the same cycle is discarded, even though in_ready may read 1.
  - flush and out_fire in the same cycle: the entry counts as consumed; the stage is still EMPTY afterwards.
  - Payload registers need not be cleared.
- Bubble gating:
  - out_ctrl and out_rd are ANDed with out_valid, so a bubble never writes memory or the register file.
  - The same applies to out_data when CLEAR_DATA_ON_BUBBLE=1.
- stall_cnt:
  - Increments by 1 each cycle out_valid & !out_ready; holds at all-ones.
  - stall_cnt_clr has priority over increment.
  - Flush does not clear stall_cnt.
- Reset overrides flush and all other activity. Reset asserted mid-transfer drops all entries; in_ready is 1 the cycle after reset.
- Simultaneous in_valid with reset: the input is ignored.

Decomposition:
- Package pipe_pkg holds:
  - state encoding (ST_EMPTY, ST_ONE, ST_FULL);
  - ctrl bit indices CTRL_MEM_WEN=0, CTRL_WB_SEL=1, CTRL_REG_WB=2, CTRL_AUIPC=3;
  - a default zero constant for the control bundle.
- One sub-module, pipe_slot_reg: valid bit plus payload register with load, clear and reset.
- Instantiate it twice, as main and skid.

Test Plan:
- Reset then stream: reset 2 cycles; in_valid=1 with in_data word0=0x10,0x11,0x12 on consecutive cycles, out_ready=1 -> out_data word0 shows 0x10,0x11,0x12 one cycle later each; out_valid=1 for 3 cycles; in_ready stays 1.
- Backpressure fill: out_ready=0, send A=0xA, then B=0xB -> out shows A held; in_ready=0 after B. Raise out_ready -> A, then B, then out_valid=0. stall_cnt equals the number of held cycles.
- Flush in FULL: fill with A,B then flush=1 with in_valid=1, C=0xC -> next cycle out_valid=0, in_ready=1, out_ctrl=0, out_rd=0; C never appears.
- Bubble gating: in_ctrl=4'b0101, in_rd=5'd7, accept then drain -> out_ctrl=4'b0101 and out_rd=7 while valid; both 0 the cycle after. With CLEAR_DATA_ON_BUBBLE=1, out_data is also 0.
- Counter saturation: CNT_W=3, hold out_ready=0 with a valid entry for 10 cycles -> stall_cnt=7. Pulse stall_cnt_clr with the stall still active -> 0 that edge, then counts 1,2,...
- Reset mid-operation: FULL state, assert reset 1 cycle -> out_valid=0, in_ready=1, stall_cnt=0; the next accepted entry D emerges normally.
